// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and types for the segment-bus reader.
// Segment patterns are active-low, bit0=a .. bit6=g.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [3:0] ERR_CODE   = 4'hE;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HOLD  = 2'd2
  } stab_state_e;

  typedef struct packed {
    logic [3:0] code;
    logic       err;
  } digit_t;

endpackage

// File: rtl/seg7tobcd.sv
// Combinational 7-segment to BCD decoder; blank maps to BLANK_CODE,
// anything unrecognised maps to ERR_CODE with err set.
module seg7tobcd
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       err
);

  always_comb begin
    code = ERR_CODE;
    err  = 1'b1;
    unique case (seg)
      SEG_0:     begin code = 4'd0;       err = 1'b0; end
      SEG_1:     begin code = 4'd1;       err = 1'b0; end
      SEG_2:     begin code = 4'd2;       err = 1'b0; end
      SEG_3:     begin code = 4'd3;       err = 1'b0; end
      SEG_4:     begin code = 4'd4;       err = 1'b0; end
      SEG_5:     begin code = 4'd5;       err = 1'b0; end
      SEG_6:     begin code = 4'd6;       err = 1'b0; end
      SEG_7:     begin code = 4'd7;       err = 1'b0; end
      SEG_8:     begin code = 4'd8;       err = 1'b0; end
      SEG_9:     begin code = 4'd9;       err = 1'b0; end
      SEG_BLANK: begin code = BLANK_CODE; err = 1'b0; end
      default:   begin code = ERR_CODE;   err = 1'b1; end
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// Reads a multiplexed 7-segment display bus: synchronizes, waits for each
// digit strobe to settle, decodes it and publishes a frame once all digits are seen.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int NDIG          = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        seg,
  input  logic [NDIG-1:0]   dig_sel,
  output logic [4*NDIG-1:0] bcd,
  output logic              frame_valid,
  output logic              frame_err,
  output logic [NDIG-1:0]   digit_err
);

  localparam int              WW        = NDIG + 7;
  localparam logic [WW-1:0]   IDLE_WORD = {{NDIG{1'b0}}, SEG_BLANK};
  localparam logic [7:0]      CNT_LAST  = 8'(STABLE_CYCLES - 1);

  logic [WW-1:0]             sync1_q, sync2_q;
  stab_state_e               state_q, state_d;
  logic [7:0]                cnt_q, cnt_d;
  logic [NDIG-1:0]           seen_q, seen_d;
  digit_t [NDIG-1:0]         pend_q, pend_d;
  logic [NDIG-1:0][3:0]      bcd_q, bcd_d;
  logic [NDIG-1:0]           digit_err_q, digit_err_d;
  logic                      frame_valid_q, frame_valid_d;
  logic                      frame_err_q, frame_err_d;

  logic [NDIG-1:0] sel_s;
  logic [6:0]      seg_s;
  logic            chg, cap, cap_ok, frame_done;
  logic [3:0]      dec_code;
  logic            dec_err;

  assign sel_s = sync2_q[WW-1:7];
  assign seg_s = sync2_q[6:0];

  // Change is seen one stage ahead (at the edge that loads the new word into
  // the second flop) so the capture edge falls exactly STABLE_CYCLES later.
  assign chg        = (sync1_q != sync2_q);
  assign cap_ok     = cap && $onehot(sel_s);
  assign frame_done = &seen_q;

  seg7tobcd u_dec (
    .seg  (seg_s),
    .code (dec_code),
    .err  (dec_err)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    unique case (state_q)
      ST_WAIT: begin
        if (chg) begin
          state_d = ST_COUNT;
          cnt_d   = '0;
        end
      end
      ST_COUNT: begin
        if (chg) begin
          state_d = ST_WAIT;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HOLD;
          cap     = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_HOLD: begin
        if (chg) begin
          state_d = ST_COUNT;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  always_comb begin
    pend_d = pend_q;
    seen_d = seen_q;
    if (frame_done) begin
      seen_d = '0;
      for (int i = 0; i < NDIG; i++) pend_d[i].err = 1'b0;
    end
    // A capture on the publishing edge starts the next frame rather than being lost.
    if (cap_ok) begin
      for (int i = 0; i < NDIG; i++) begin
        if (sel_s[i]) begin
          pend_d[i].code = dec_code;
          pend_d[i].err  = dec_err;
          seen_d[i]      = 1'b1;
        end
      end
    end
  end

  always_comb begin
    bcd_d         = bcd_q;
    digit_err_d   = digit_err_q;
    frame_valid_d = frame_done;
    frame_err_d   = 1'b0;
    if (frame_done) begin
      for (int i = 0; i < NDIG; i++) begin
        bcd_d[i]       = pend_q[i].code;
        digit_err_d[i] = pend_q[i].err;
      end
      frame_err_d = |digit_err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= IDLE_WORD;
      sync2_q       <= IDLE_WORD;
      state_q       <= ST_WAIT;
      cnt_q         <= '0;
      seen_q        <= '0;
      pend_q        <= '0;
      bcd_q         <= {NDIG{BLANK_CODE}};
      digit_err_q   <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      sync1_q       <= {dig_sel, seg};
      sync2_q       <= sync1_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      seen_q        <= seen_d;
      pend_q        <= pend_d;
      bcd_q         <= bcd_d;
      digit_err_q   <= digit_err_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign bcd         = bcd_q;
  assign digit_err   = digit_err_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Scoreboarded bench for seg7_reader: directed scenarios plus random segment
// traffic against a segment-level reference model.
module tb_seg7_reader;

  localparam int NDIG = 4;
  localparam int S    = 4;
  localparam logic [6:0] PAT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                      7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  localparam logic [10:0] IDLE = {4'b0000, 7'h7F};

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [6:0]      seg = 7'h7F;
  logic [NDIG-1:0] dig_sel = '0;
  logic [15:0]     bcd;
  logic            frame_valid, frame_err;
  logic [NDIG-1:0] digit_err;

  seg7_reader #(.NDIG(NDIG), .STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg         (seg),
    .dig_sel     (dig_sel),
    .bcd         (bcd),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .digit_err   (digit_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  err;
    logic        fe;
  } frame_t;

  frame_t      exp_q[$];
  int          n_vec = 0;
  int          n_bad = 0;

  // Reference model state: pending digits of the frame being assembled, and
  // whether the previous pin segment started a stability count it never finished.
  logic [3:0]      m_code [NDIG];
  logic            m_err  [NDIG];
  logic [NDIG-1:0] m_seen;
  bit              m_aborted;
  logic [10:0]     cur_word;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void ref_decode(input logic [6:0] s, output logic [3:0] c, output logic e);
    c = 4'hE;
    e = 1'b1;
    if (s == 7'h7F) begin c = 4'hF; e = 1'b0; end
    for (int i = 0; i < 10; i++)
      if (s == PAT[i]) begin c = 4'(i); e = 1'b0; end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_seen    = '0;
    m_aborted = 1'b0;
    cur_word  = IDLE;
    for (int i = 0; i < NDIG; i++) begin m_code[i] = 4'hF; m_err[i] = 1'b0; end
  endfunction

  // One pin segment: a new word held for len sampling edges. Stimulus never
  // uses len of S or S+1, keeping capture and the next change on distinct edges.
  function automatic void model_seg(input logic [NDIG-1:0] sel, input logic [6:0] s, input int len);
    bit     armed, long_seg;
    frame_t f;
    armed     = !m_aborted;
    long_seg  = (len >= S);
    m_aborted = armed && !long_seg;
    cur_word  = {sel, s};
    if (armed && long_seg && $onehot(sel)) begin
      for (int i = 0; i < NDIG; i++)
        if (sel[i]) begin
          ref_decode(s, m_code[i], m_err[i]);
          m_seen[i] = 1'b1;
        end
      if (&m_seen) begin
        for (int i = 0; i < NDIG; i++) begin
          f.bcd[4*i +: 4] = m_code[i];
          f.err[i]        = m_err[i];
        end
        f.fe = |f.err;
        exp_q.push_back(f);
        m_seen = '0;
        for (int i = 0; i < NDIG; i++) m_err[i] = 1'b0;
      end
    end
  endfunction

  task automatic apply(input logic [NDIG-1:0] sel, input logic [6:0] s, input int len);
    @(negedge clk);
    seg     = s;
    dig_sel = sel;
    model_seg(sel, s, len);
    repeat (len) @(posedge clk);
  endtask

  // Monitor: every published frame must match the oldest expected one.
  initial begin
    frame_t f;
    forever begin
      @(posedge clk);
      #1;
      if (frame_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_frame: got bcd=%h err=%b, expected none at %0t", bcd, digit_err, $time);
        end else begin
          f = exp_q.pop_front();
          chk("frame_bcd", 32'(bcd), 32'(f.bcd));
          chk("frame_digit_err", 32'(digit_err), 32'(f.err));
          chk("frame_err", 32'(frame_err), 32'(f.fe));
        end
      end else if (frame_err) begin
        chk("frame_err_idle", 32'(frame_err), 32'd0);
      end
    end
  end

  initial begin
    logic [NDIG-1:0] sel;
    logic [6:0]      s;
    int              len, r;

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_bcd", 32'(bcd), 32'hFFFF);
    chk("reset_digit_err", 32'(digit_err), 32'd0);
    chk("reset_frame_valid", 32'(frame_valid), 32'd0);
    chk("reset_frame_err", 32'(frame_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Digits "1".."4" -> 4321
    for (int d = 0; d < NDIG; d++) apply(4'(1 << d), PAT[d+1], 10);

    // Digit 0 "5", digit 1 invalid, digit 2 blank, digit 3 "9"
    apply(4'b0001, PAT[5], 10);
    apply(4'b0010, 7'h55, 10);
    apply(4'b0100, 7'h7F, 10);
    apply(4'b1000, PAT[9], 10);

    // Short glitch on digit 0 must not replace the settled "7"
    apply(4'b0001, PAT[7], 10);
    apply(4'b0001, PAT[3], 3);
    apply(4'b0001, PAT[7], 10);
    for (int d = 1; d < NDIG; d++) apply(4'(1 << d), PAT[d], 10);

    // Two strobes at once: never captured
    apply(4'b0110, PAT[8], 20);

    // Frame latency from the final digit's pin change
    for (int d = 0; d < 3; d++) apply(4'(1 << d), PAT[d+6], 10);
    @(negedge clk);
    seg     = PAT[2];
    dig_sel = 4'b1000;
    model_seg(4'b1000, PAT[2], 10);
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (i == 6) chk("latency_early", 32'(frame_valid), 32'd0);
      if (i == 7) chk("latency_k6", 32'(frame_valid), 32'd1);
    end

    // Reset mid-frame discards the partial frame
    for (int d = 0; d < 3; d++) apply(4'(1 << d), PAT[d], 10);
    @(negedge clk);
    rst_n   = 1'b0;
    seg     = 7'h7F;
    dig_sel = '0;
    model_reset();
    #1;
    chk("midrst_bcd", 32'(bcd), 32'hFFFF);
    chk("midrst_digit_err", 32'(digit_err), 32'd0);
    chk("midrst_frame_valid", 32'(frame_valid), 32'd0);
    chk("midrst_frame_err", 32'(frame_err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    apply(4'b1000, PAT[4], 10);
    for (int d = 0; d < 3; d++) apply(4'(1 << d), PAT[9-d], 10);

    // Random traffic
    repeat (300) begin
      r = int'($urandom_range(0, 9));
      if (r < 8)       sel = 4'(1 << $urandom_range(0, 3));
      else if (r == 8) sel = '0;
      else             sel = 4'($urandom);
      r = int'($urandom_range(0, 13));
      if (r < 10)       s = PAT[r];
      else if (r == 10) s = 7'h7F;
      else              s = 7'($urandom);
      if ($urandom_range(0, 3) == 0) len = int'($urandom_range(1, S-1));
      else                           len = int'($urandom_range(S+2, S+8));
      if ({sel, s} == cur_word) s = s ^ 7'h01;
      apply(sel, s, len);
    end

    repeat (20) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
